// File: rtl/tpu_drain_defs.sv
// Shared definitions for the results-SRAM drain path: FSM state encoding,
// lane counter width and the lane sign-extension helper.
package tpu_drain_defs;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WT   = 3'd2,
      ST_LD   = 3'd3,
      ST_TX   = 3'd4,
      ST_FIN  = 3'd5
   } drain_state_t;

   localparam int DEF_MATRIX_SIZE = 8;
   localparam int LANE_CNT_W      = $clog2(DEF_MATRIX_SIZE);
   localparam int SEXT_MAX_W      = 64;

   // Sign-extends the low bw bits of val to SEXT_MAX_W bits (bw <= SEXT_MAX_W).
   function automatic logic [SEXT_MAX_W-1:0] sign_extend(input logic [SEXT_MAX_W-1:0] val,
                                                         input int bw);
      logic signed [SEXT_MAX_W-1:0] tmp;
      tmp = $signed(val << (SEXT_MAX_W - bw));
      return $unsigned(tmp >>> (SEXT_MAX_W - bw));
   endfunction

endpackage

// File: rtl/result_lane_serializer.sv
// Holds one result word and presents it lane by lane (lane 0 first) as
// sign-extended beats on a valid/ready interface.
module result_lane_serializer
   import tpu_drain_defs::*;
#(
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int OUT_BW         = 32
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   load,
   input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]  load_word,
   input  logic                                   load_last,
   input  logic                                   out_ready,
   output logic                                   out_valid,
   output logic [OUT_BW-1:0]                      out_data,
   output logic                                   out_last,
   output logic                                   final_accept
);

   localparam int LW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam logic [LW-1:0] LANE_MAX = LW'(MATRIX_SIZE - 1);
   localparam int WW = MATRIX_SIZE * PARTIAL_SUM_BW;

   logic [WW-1:0] shreg;
   logic [LW-1:0] lane_cnt;
   logic          last_word;
   logic          accept;

   assign accept       = out_valid & out_ready;
   assign final_accept = accept & (lane_cnt == LANE_MAX);

   // A load wins over an accept so a new word can follow the final lane back-to-back.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg     <= '0;
         lane_cnt  <= '0;
         out_valid <= 1'b0;
         last_word <= 1'b0;
      end else if (load) begin
         shreg     <= load_word;
         lane_cnt  <= '0;
         out_valid <= 1'b1;
         last_word <= load_last;
      end else if (accept) begin
         shreg <= shreg >> PARTIAL_SUM_BW;
         if (lane_cnt == LANE_MAX) begin
            out_valid <= 1'b0;
            lane_cnt  <= '0;
         end else begin
            lane_cnt <= lane_cnt + 1'b1;
         end
      end
   end

   assign out_data = OUT_BW'(sign_extend(SEXT_MAX_W'(shreg[PARTIAL_SUM_BW-1:0]), PARTIAL_SUM_BW));
   assign out_last = out_valid & last_word & (lane_cnt == LANE_MAX);

endmodule

// File: rtl/result_drain_ctrl.sv
// Results-SRAM drain controller: reads num_words words from base_addr and
// streams their lanes to the host. Optional RESULT_DRAIN_PREFETCH_EN overlaps
// the next word's read with the current word's transmission.
//
// state   | meaning
// IDLE    | waiting for start
// RD      | SRAM read strobe issued for the current word
// WT      | SRAM read latency cycle
// LD      | read data captured into the lane serializer
// TX      | lanes being streamed to the host
// FIN     | job complete, done pulse
module result_drain_ctrl
   import tpu_drain_defs::*;
#(
   parameter int ADDRESSSIZE    = 10,
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int OUT_BW         = 32
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   start,
   input  logic [ADDRESSSIZE-1:0]                 base_addr,
   input  logic [ADDRESSSIZE:0]                   num_words,
   output logic                                   rd_en,
   output logic [ADDRESSSIZE-1:0]                 rd_addr,
   input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]  rd_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [OUT_BW-1:0]                      out_data,
   output logic                                   out_last,
   output logic                                   busy,
   output logic                                   done
);

   localparam int WW = MATRIX_SIZE * PARTIAL_SUM_BW;

   drain_state_t           state, state_nxt;
   logic [ADDRESSSIZE:0]   num_q;
   logic [ADDRESSSIZE:0]   word_idx;
   logic [ADDRESSSIZE-1:0] next_addr;
   logic [ADDRESSSIZE-1:0] issue_addr;
   logic                   issue;
   logic                   more_words;
   logic                   ser_load;
   logic                   ser_load_last;
   logic [WW-1:0]          ser_word;
   logic                   final_accept;

   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_FIN);
   assign more_words = ((word_idx + 1'b1) != num_q);
   assign issue_addr = (state == ST_IDLE) ? base_addr : next_addr;

`ifdef RESULT_DRAIN_PREFETCH_EN
   // Prefetch needs at least three lanes so the next word lands before the final lane.
   logic [ADDRESSSIZE:0] rd_cnt;
   logic [WW-1:0]        hold;
   logic                 hold_valid;
   logic                 pf_cap;
   logic                 pf_issue;

   assign pf_issue = (state == ST_TX) && (rd_cnt != num_q) && !hold_valid && !pf_cap && !rd_en;
`endif

   always_comb begin
      state_nxt     = state;
      issue         = 1'b0;
      ser_load      = 1'b0;
      ser_word      = rd_data;
      ser_load_last = !more_words;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_nxt = ST_FIN;
               end else begin
                  state_nxt = ST_RD;
                  issue     = 1'b1;
               end
            end
         end
         ST_RD: state_nxt = ST_WT;
         ST_WT: state_nxt = ST_LD;
         ST_LD: begin
            ser_load  = 1'b1;
            state_nxt = ST_TX;
         end
         ST_TX: begin
            if (final_accept) begin
               if (!more_words) begin
                  state_nxt = ST_FIN;
               end else begin
`ifdef RESULT_DRAIN_PREFETCH_EN
                  ser_load      = 1'b1;
                  ser_word      = hold_valid ? hold : rd_data;
                  ser_load_last = ((word_idx + (ADDRESSSIZE+1)'(2)) == num_q);
`else
                  state_nxt = ST_RD;
                  issue     = 1'b1;
`endif
               end
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
`ifdef RESULT_DRAIN_PREFETCH_EN
      issue = issue | pf_issue;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         next_addr <= '0;
         num_q     <= '0;
         word_idx  <= '0;
      end else begin
         state <= state_nxt;
         rd_en <= issue;
         if (issue) begin
            rd_addr   <= issue_addr;
            next_addr <= issue_addr + 1'b1;
         end
         if ((state == ST_IDLE) && start) begin
            num_q    <= num_words;
            word_idx <= '0;
         end
         if ((state == ST_TX) && final_accept && more_words) begin
            word_idx <= word_idx + 1'b1;
         end
      end
   end

`ifdef RESULT_DRAIN_PREFETCH_EN
   // pf_cap marks the cycle in which a prefetch read's data sits on rd_data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_cnt     <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         pf_cap     <= 1'b0;
      end else begin
         pf_cap <= rd_en && (state == ST_TX);
         if (state == ST_IDLE) begin
            rd_cnt <= {{ADDRESSSIZE{1'b0}}, issue};
         end else if (issue) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if ((state == ST_IDLE) || (ser_load && (state == ST_TX))) begin
            hold_valid <= 1'b0;
         end else if (pf_cap) begin
            hold       <= rd_data;
            hold_valid <= 1'b1;
         end
      end
   end
`endif

   result_lane_serializer #(
      .MATRIX_SIZE    (MATRIX_SIZE),
      .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
      .OUT_BW         (OUT_BW)
   ) u_ser (
      .clk          (clk),
      .rstn         (rstn),
      .load         (ser_load),
      .load_word    (ser_word),
      .load_last    (ser_load_last),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .final_accept (final_accept)
   );

endmodule
